// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide unit.
// Op codes match the decoder's md_op field.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // MUL is run unsigned: the low product half does not depend on operand signs.
  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring shift-subtract divide.
// After XLEN steps {hi, lo} holds the product, or hi = remainder and lo = quotient.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q, hi_nxt, lo_nxt;
  logic            div_q;
  logic [XLEN:0]   mul_sum, rem_sh, diff;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    // rem_sh < 2*b, so a 33-bit difference carries the correct sign
    diff    = rem_sh - {1'b0, b_q};
    hi_nxt  = mul_sum[XLEN:1];
    lo_nxt  = {mul_sum[0], lo_q[XLEN-1:1]};
    if (div_q) begin
      if (diff[XLEN]) begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= div_mode;
    end else if (step) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the front end while iterating.
// state | meaning
// IDLE  | waiting for an M-extension op in EX
// BUSY  | one iteration per cycle; early exit for div-by-zero / overflow when FAST_SPEC
// DONE  | result_o presented with a one-cycle valid_o; EX advances on this edge
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e           state, state_nxt;
  md_op_e              op_in, op_q;
  logic [CW-1:0]       cnt;
  logic                accept, neg_a, neg_b, div_zero, div_ovf;
  logic                neg_res_q, neg_rem_q, spec_q;
  logic [XLEN-1:0]     mag_a, mag_b, spec_res, spec_res_q, result_q, result_fix;
  logic [XLEN-1:0]     core_hi, core_lo;
  logic [2*XLEN-1:0]   prod, prod_fix;

  assign op_in    = md_op_e'(md_op_i);
  assign accept   = (state == ST_IDLE) && start_i && !flush_i;
  assign neg_a    = op_a_signed(op_in) && op_a_i[XLEN-1];
  assign neg_b    = op_b_signed(op_in) && op_b_i[XLEN-1];
  assign mag_a    = neg_a ? -op_a_i : op_a_i;
  assign mag_b    = neg_b ? -op_b_i : op_b_i;
  assign div_zero = op_is_div(op_in) && (op_b_i == '0);
  assign div_ovf  = (op_in inside {MD_DIV, MD_REM}) &&
                    (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
  // Special results are fixed at start so the sign fix-up never touches them.
  assign spec_res = div_zero ? (op_is_rem(op_in) ? op_a_i : '1)
                             : (op_is_rem(op_in) ? '0 : op_a_i);

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .step     (state == ST_BUSY),
    .div_mode (op_is_div(op_in)),
    .a        (mag_a),
    .b        (mag_b),
    .hi       (core_hi),
    .lo       (core_lo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flush_i) state_nxt = ST_IDLE;
        else if ((cnt == CW'(XLEN-1)) || (FAST_SPEC && spec_q)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = neg_res_q ? -prod : prod;
    case (op_q)
      MD_MUL:                     result_fix = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            result_fix = neg_res_q ? -core_lo : core_lo;
      default:                    result_fix = neg_rem_q ? -core_hi : core_hi;
    endcase
    if (spec_q) result_fix = spec_res_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= MD_MUL;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= '0;
        op_q       <= op_in;
        neg_res_q  <= neg_a ^ neg_b;
        neg_rem_q  <= neg_a;
        spec_q     <= div_zero || div_ovf;
        spec_res_q <= spec_res;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (valid_o) result_q <= result_fix;
    end
  end

  assign busy_o   = (state == ST_BUSY);
  assign valid_o  = (state == ST_DONE) && !flush_i;
  assign stall_o  = accept || (state == ST_BUSY);
  assign result_o = valid_o ? result_fix : result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, random ops against an
// arithmetic reference, flush, async reset mid-operation and back-to-back starts.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, busy, valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start),
    .md_op_i  (md_op),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .flush_i  (flush),
    .stall_o  (stall),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  // Entered and left just after a rising edge; start is presented in "cycle 0".
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    int          cyc;
    int          stall_cnt;
    logic [31:0] expv;
    expv      = ref_md(op, a, b);
    start     = 1'b1;
    md_op     = op;
    op_a      = a;
    op_b      = b;
    cyc       = 0;
    stall_cnt = 0;
    @(negedge clk);
    while (valid !== 1'b1 && cyc < 100) begin
      if (stall === 1'b1) stall_cnt++;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(cyc), 32'(ref_latency(op, a, b)));
    check({tag, "_result"}, result, expv);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(ref_latency(op, a, b)));
    check({tag, "_stall_in_done"}, {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check({tag, "_pulse_one_cycle"}, {31'h0, valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] prev;
    int          vcount;
    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    md_op   = 3'd0;
    op_a    = '0;
    op_b    = '0;
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul_7x-3",     3'd0, 32'h7,          32'hFFFF_FFFD, 1'b0);
    run_op("mulhu_ff",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op("mulh_ff",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu_ff",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op("div_-7_2",     3'd4, 32'hFFFF_FFF9,  32'h2,         1'b0);
    run_op("rem_-7_2",     3'd6, 32'hFFFF_FFF9,  32'h2,         1'b0);
    run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         1'b0);
    run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         1'b0);
    run_op("div_5_0",      3'd4, 32'd5,          32'h0,         1'b0);
    run_op("rem_5_0",      3'd6, 32'd5,          32'h0,         1'b0);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op("rem_neg_0",    3'd6, 32'hFFFF_FF00,  32'h0,         1'b0);
    run_op("divu_ovfpat",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0);
    end

    // flush during the 10th BUSY cycle
    prev  = result;
    start = 1'b1;
    md_op = 3'd0;
    op_a  = $urandom;
    op_b  = $urandom;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    #1;
    check("flush_busy_before", {31'h0, busy}, 32'h1);
    check("flush_valid_during", {31'h0, valid}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle_next", {31'h0, busy}, 32'h0);
    check("flush_stall_drop", {31'h0, stall}, 32'h0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    check("flush_no_valid", 32'(vcount), 32'h0);
    check("flush_result_held", result, prev);
    @(posedge clk);
    #1;

    // async reset in the middle of BUSY
    start = 1'b1;
    md_op = 3'd5;
    op_a  = 32'd1000;
    op_b  = 32'd3;
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_valid", {31'h0, valid}, 32'h0);
    check("midreset_stall", {31'h0, stall}, 32'h0);
    check("midreset_result", result, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back with start held: second op presented the cycle after DONE
    run_op("b2b_divu", 3'd5, 32'd12345, 32'd17, 1'b1);
    run_op("b2b_mul",  3'd0, 32'hFFFF_FFF0, 32'd9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
